score_bcd_display: RTL and testbench
====================================

# score_bcd_display

Parametrised sequential binary-to-BCD converter and multi-digit seven-segment driver for the score path. It accepts a BIN_W-bit unsigned value on a start strobe and converts it with an iterative shift-add-3 (double-dabble) engine, one bit per clock. It registers DIGITS BCD digits with overflow saturation and optional leading-zero blanking, and drives one active-low seven-segment pattern per digit directly to the HEX displays.

## Interface
- BIN_W, 8: width of the binary input; legal range 4..20.
- DIGITS, 3: number of decimal digits produced and displayed; legal range 1..6.
- BLANK_LZ, 1: 1 blanks leading zero digits; 0 shows all digits.
- clk  input  1  system clock; all state changes on its rising edge.
- resetn  input  1  asynchronous, active-low reset.
- start  input  1  conversion request; sampled only in IDLE.
- bin_in  input  BIN_W  unsigned value; captured on the accepted start edge.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when new results are valid.
- overflow  output  1  registered; set when the last result was saturated.
- bcd_out  output  4*DIGITS  registered digits; digit k in bits [4k+3:4k], digit 0 = ones.
- seg_out  output  7*DIGITS  active-low segments; digit k in bits [7k+6:7k], bit 0 = a ... bit 6 = g.

## Operation
- FSM states: IDLE, SHIFT, LOAD.
- IDLE:
  - start=1 captures bin_in into the shift register and clears the scratch BCD accumulator.
  - Loads bit counter = BIN_W and moves to SHIFT.
- SHIFT: each cycle:
  - Adds 3 to every scratch nibble ≥ 5.
  - Shifts {scratch, shift register} left by one.
  - Decrements the counter. When the counter reaches 1 on this cycle, moves to LOAD.
- Scratch width:
  - The accumulator holds ceil(BIN_W*log10(2))+1 nibbles, so no carry is lost.
  - Digits above DIGITS are used only for overflow detection.
- LOAD:
  - If any scratch nibble at index ≥ DIGITS is nonzero, bcd_out = all nines and overflow = 1.
  - Otherwise bcd_out = scratch[4*DIGITS-1:0] and overflow = 0.
  - done pulses, blank mask updates, return to IDLE.
- Blank mask: with BLANK_LZ=1, digit k (k≥1) is blanked when it and every digit above it are 0. Digit 0 is never blanked. With BLANK_LZ=0 the mask is all zeros.
- Segment patterns (active-low, g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Blanked digit = 1111111.
- seg_out is combinational from the registered bcd_out and the registered blank mask. It never shows intermediate scratch values.
- start while busy (SHIFT or LOAD) is ignored and is not queued. bin_in changes during conversion have no effect.
- Every value 0 .. 10^DIGITS−1 converts exactly; no value is treated specially.

## Timing
- Reset (async assert, sync-safe deassert):
  - FSM = IDLE; busy = 0, done = 0, overflow = 0, bcd_out = 0.
  - Blank mask = all digits except digit 0 blanked (BLANK_LZ=1), or none blanked (BLANK_LZ=0).
  - So seg_out shows "0" in digit 0.
- Start accepted at edge T0:
  - busy = 1 from T0 through the LOAD edge.
  - SHIFT occupies edges T1..T(BIN_W).
  - LOAD registers outputs at edge T(BIN_W+1); done is high for the cycle after that edge and busy is low in that same cycle.
- Latency: BIN_W+1 clocks from the accepted start to done. Throughput: one conversion per BIN_W+2 clocks at most. start held high continuously re-triggers on the first IDLE cycle after done.
- Reset asserted mid-conversion: the conversion is abandoned, outputs go to reset values immediately, and done does not pulse.
- Outputs bcd_out, overflow and seg_out hold their last values between conversions.

## Test plan
- Reset, no start: bcd_out=0x000, seg_out digit0=1000000, digits1..2=1111111, busy=0, done=0.
- BIN_W=8, DIGITS=3, bin_in=251 at start: done exactly 9 clocks later, bcd_out=0x251, overflow=0, seg=0100100/0010010/1111001.
- bin_in=7 then bin_in=0: bcd_out=0x007 with digits 2,1 blank; then 0x000 showing "0" only in digit 0. Repeat with BLANK_LZ=0: all three digits show 1000000 for the zero case.
- DIGITS=2, bin_in=150: bcd_out=0x99, overflow=1. Next conversion bin_in=42: bcd_out=0x42, overflow=0.
- Start pulses with new bin_in on every cycle during SHIFT: exactly one done is produced, and its result equals the value captured first.
- Sweep BIN_W=10, DIGITS=4 over 0..1023, plus a reset asserted at SHIFT cycle 4: every result matches the decimal model, and the reset cycle yields reset values with no done.

Source files
------------

// File: rtl/score_bcd_display.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per clock) with
// overflow saturation, leading-zero blanking and active-low seven-segment drive.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// SHIFT | one add-3/shift step per clock over all BIN_W input bits
// LOAD  | saturate or copy scratch digits to outputs, pulse done
module score_bcd_display #(
    parameter int BIN_W    = 8,
    parameter int DIGITS   = 3,
    parameter int BLANK_LZ = 1
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic [BIN_W-1:0]    bin_in,
    output logic                busy,
    output logic                done,
    output logic                overflow,
    output logic [4*DIGITS-1:0] bcd_out,
    output logic [7*DIGITS-1:0] seg_out
);

    function automatic int dec_digits(input int w);
        int v;
        int n;
        v = (1 << w) - 1;
        n = 0;
        while (v > 0) begin
            v = v / 10;
            n = n + 1;
        end
        return n;
    endfunction

    // Always keep at least one nibble above DIGITS so overflow has something to inspect.
    localparam int LOG_NIB = dec_digits(BIN_W) + 1;
    localparam int SCR_NIB = (LOG_NIB > DIGITS) ? LOG_NIB : DIGITS + 1;
    localparam int SCR_W   = 4 * SCR_NIB;
    localparam int CNT_W   = $clog2(BIN_W + 1);
    localparam logic [DIGITS-1:0] BLANK_RST = (BLANK_LZ != 0) ? ~DIGITS'(1) : '0;

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

    state_t              state, state_nxt;
    logic [BIN_W-1:0]    shreg;
    logic [SCR_W-1:0]    scratch, scratch_adj;
    logic [CNT_W-1:0]    cnt;
    logic [DIGITS-1:0]   blank, blank_nxt;
    logic [4*DIGITS-1:0] bcd_nxt;
    logic                ovf_nxt;
    logic                all_zero;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (cnt == CNT_W'(1)) state_nxt = LOAD;
            LOAD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        scratch_adj = scratch;
        for (int k = 0; k < SCR_NIB; k++) begin
            if (scratch[4*k +: 4] >= 4'd5) scratch_adj[4*k +: 4] = scratch[4*k +: 4] + 4'd3;
        end
        ovf_nxt = |scratch[SCR_W-1:4*DIGITS];
        bcd_nxt = ovf_nxt ? {DIGITS{4'h9}} : scratch[4*DIGITS-1:0];
        // Walk down from the top digit; blanking stops at the first nonzero one.
        blank_nxt = '0;
        all_zero  = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            if (bcd_nxt[4*k +: 4] != 4'd0) all_zero = 1'b0;
            blank_nxt[k] = (BLANK_LZ != 0) && all_zero;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            shreg    <= '0;
            scratch  <= '0;
            cnt      <= '0;
            done     <= 1'b0;
            overflow <= 1'b0;
            bcd_out  <= '0;
            blank    <= BLANK_RST;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg   <= bin_in;
                        scratch <= '0;
                        cnt     <= CNT_W'(BIN_W);
                    end
                end
                SHIFT: begin
                    {scratch, shreg} <= {scratch_adj, shreg} << 1;
                    cnt              <= cnt - CNT_W'(1);
                end
                LOAD: begin
                    bcd_out  <= bcd_nxt;
                    overflow <= ovf_nxt;
                    blank    <= blank_nxt;
                    done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);

    always_comb begin
        seg_out = '0;
        for (int k = 0; k < DIGITS; k++) begin
            seg_out[7*k +: 7] = blank[k] ? 7'b1111111 : seg7(bcd_out[4*k +: 4]);
        end
    end

endmodule

// File: tb/tb_score_bcd_display.sv
// Bench for score_bcd_display: four parameterisations share stimulus and are
// checked every cycle against a decimal-arithmetic model, plus literal checks.
module tb_score_bcd_display;

    localparam int P_BW [4] = '{8, 8, 8, 10};
    localparam int P_D  [4] = '{3, 3, 2, 4};
    localparam int P_LZ [4] = '{1, 0, 1, 1};
    localparam logic [6:0] SEG_TAB [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                            7'b0000000, 7'b0010000};

    logic       clk = 1'b0;
    logic       resetn;
    logic       start;
    logic [9:0] bin;

    logic busy_a, done_a, ovf_a, busy_b, done_b, ovf_b;
    logic busy_c, done_c, ovf_c, busy_d, done_d, ovf_d;
    logic [11:0] bcd_a, bcd_b;
    logic [7:0]  bcd_c;
    logic [15:0] bcd_d;
    logic [20:0] seg_a, seg_b;
    logic [13:0] seg_c;
    logic [27:0] seg_d;

    score_bcd_display #(.BIN_W(8), .DIGITS(3), .BLANK_LZ(1)) dut_a (
        .clk(clk), .resetn(resetn), .start(start), .bin_in(bin[7:0]),
        .busy(busy_a), .done(done_a), .overflow(ovf_a), .bcd_out(bcd_a), .seg_out(seg_a));
    score_bcd_display #(.BIN_W(8), .DIGITS(3), .BLANK_LZ(0)) dut_b (
        .clk(clk), .resetn(resetn), .start(start), .bin_in(bin[7:0]),
        .busy(busy_b), .done(done_b), .overflow(ovf_b), .bcd_out(bcd_b), .seg_out(seg_b));
    score_bcd_display #(.BIN_W(8), .DIGITS(2), .BLANK_LZ(1)) dut_c (
        .clk(clk), .resetn(resetn), .start(start), .bin_in(bin[7:0]),
        .busy(busy_c), .done(done_c), .overflow(ovf_c), .bcd_out(bcd_c), .seg_out(seg_c));
    score_bcd_display #(.BIN_W(10), .DIGITS(4), .BLANK_LZ(1)) dut_d (
        .clk(clk), .resetn(resetn), .start(start), .bin_in(bin),
        .busy(busy_d), .done(done_d), .overflow(ovf_d), .bcd_out(bcd_d), .seg_out(seg_d));

    always #5 clk = ~clk;

    logic        busy_v [4], done_v [4], ovf_v [4];
    logic [23:0] bcd_v  [4];
    logic [41:0] seg_v  [4];
    assign busy_v = '{busy_a, busy_b, busy_c, busy_d};
    assign done_v = '{done_a, done_b, done_c, done_d};
    assign ovf_v  = '{ovf_a, ovf_b, ovf_c, ovf_d};
    assign bcd_v  = '{24'(bcd_a), 24'(bcd_b), 24'(bcd_c), 24'(bcd_d)};
    assign seg_v  = '{42'(seg_a), 42'(seg_b), 42'(seg_c), 42'(seg_d)};

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: cycles remaining until done, captured value, expected outputs.
    int          rem [4];
    int          val [4];
    logic        exp_busy [4], exp_done [4], exp_ovf [4];
    logic [23:0] exp_bcd [4];
    logic [41:0] exp_seg [4];

    function automatic void decode(input int i, input int v, output logic [23:0] b,
                                   output logic [41:0] s, output logic o);
        int lim, x, z;
        int dg [6];
        lim = 1;
        for (int k = 0; k < P_D[i]; k++) lim = lim * 10;
        o = (v >= lim);
        x = v;
        for (int k = 0; k < 6; k++) begin
            dg[k] = o ? 9 : x % 10;
            x = x / 10;
        end
        b = '0;
        s = '0;
        z = 1;
        for (int k = P_D[i] - 1; k >= 0; k--) begin
            b = b | (24'(dg[k]) << (4 * k));
            if (dg[k] != 0) z = 0;
            s = s | (42'((P_LZ[i] != 0 && k >= 1 && z != 0) ? 7'h7F : SEG_TAB[dg[k]]) << (7 * k));
        end
    endfunction

    function automatic void model_reset(input int i);
        rem[i] = 0;
        val[i] = 0;
        exp_busy[i] = 1'b0;
        exp_done[i] = 1'b0;
        decode(i, 0, exp_bcd[i], exp_seg[i], exp_ovf[i]);
    endfunction

    initial begin
        for (int i = 0; i < 4; i++) model_reset(i);
        forever begin
            @(posedge clk or negedge resetn);
            for (int i = 0; i < 4; i++) begin
                if (!resetn) begin
                    model_reset(i);
                end else begin
                    exp_done[i] = 1'b0;
                    if (rem[i] > 0) begin
                        rem[i]--;
                        if (rem[i] == 0) begin
                            decode(i, val[i], exp_bcd[i], exp_seg[i], exp_ovf[i]);
                            exp_done[i] = 1'b1;
                        end
                    end else if (start) begin
                        rem[i] = P_BW[i] + 1;
                        val[i] = int'(bin) & ((1 << P_BW[i]) - 1);
                    end
                    exp_busy[i] = (rem[i] > 0);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("busy[%0d]", i), 64'(busy_v[i]), 64'(exp_busy[i]));
                check($sformatf("done[%0d]", i), 64'(done_v[i]), 64'(exp_done[i]));
                check($sformatf("overflow[%0d]", i), 64'(ovf_v[i]), 64'(exp_ovf[i]));
                check($sformatf("bcd[%0d]", i), 64'(bcd_v[i]), 64'(exp_bcd[i]));
                check($sformatf("seg[%0d]", i), 64'(seg_v[i]), 64'(exp_seg[i]));
            end
        end
    end

    // One conversion: start for one cycle, then 14 cycles so every instance finishes.
    task automatic convert(input int v, output int lat_a, output int lat_d, output int nd_a);
        @(negedge clk);
        bin   = 10'(v);
        start = 1'b1;
        lat_a = -1;
        lat_d = -1;
        nd_a  = 0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done_a) begin
                nd_a++;
                if (lat_a < 0) lat_a = c - 1;
            end
            if (done_d && lat_d < 0) lat_d = c - 1;
        end
    endtask

    initial begin
        int la, ld, na, nd;
        resetn = 1'b0;
        start  = 1'b0;
        bin    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        resetn = 1'b1;
        @(negedge clk);
        check("rst_bcd_a", 64'(bcd_a), 64'h000);
        check("rst_seg_a", 64'(seg_a), 64'({7'h7F, 7'h7F, 7'b1000000}));
        check("rst_seg_b", 64'(seg_b), 64'({3{7'b1000000}}));
        check("rst_busy_done_a", 64'({busy_a, done_a}), 64'd0);
        check("model_rst_seg_a", 64'(exp_seg[0]), 64'({7'h7F, 7'h7F, 7'b1000000}));

        convert(251, la, ld, na);
        check("lat_a_251", 64'(la), 64'd9);
        check("lat_d_251", 64'(ld), 64'd11);
        check("bcd_a_251", 64'(bcd_a), 64'h251);
        check("ovf_a_251", 64'(ovf_a), 64'd0);
        check("seg_a_251", 64'(seg_a), 64'({7'b0100100, 7'b0010010, 7'b1111001}));
        check("model_bcd_251", 64'(exp_bcd[0]), 64'h251);

        convert(7, la, ld, na);
        check("bcd_a_7", 64'(bcd_a), 64'h007);
        check("seg_a_7", 64'(seg_a), 64'({7'h7F, 7'h7F, 7'b1111000}));
        convert(0, la, ld, na);
        check("seg_a_0", 64'(seg_a), 64'({7'h7F, 7'h7F, 7'b1000000}));
        check("seg_b_0", 64'(seg_b), 64'({3{7'b1000000}}));

        convert(150, la, ld, na);
        check("bcd_c_150", 64'(bcd_c), 64'h99);
        check("ovf_c_150", 64'(ovf_c), 64'd1);
        check("bcd_a_150", 64'(bcd_a), 64'h150);
        convert(42, la, ld, na);
        check("bcd_c_42", 64'(bcd_c), 64'h42);
        check("ovf_c_42", 64'(ovf_c), 64'd0);

        // start re-asserted with fresh bin_in through all of SHIFT
        @(negedge clk);
        bin   = 10'd123;
        start = 1'b1;
        na    = 0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c <= 8) bin = 10'($urandom);
            else        start = 1'b0;
            if (done_a) na++;
        end
        check("spam_done_cnt_a", 64'(na), 64'd1);
        check("spam_bcd_a", 64'(bcd_a), 64'h123);

        for (int v = 0; v < 1024; v++) convert(v, la, ld, na);

        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) != 0);
            bin   = 10'($urandom);
        end
        start = 1'b0;
        repeat (15) @(negedge clk);

        // reset during SHIFT cycle 4
        @(negedge clk);
        bin   = 10'd777;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        check("midrst_busy_d", 64'(busy_d), 64'd0);
        check("midrst_bcd_d", 64'(bcd_d), 64'h0000);
        check("midrst_seg_d", 64'(seg_d), 64'({7'h7F, 7'h7F, 7'h7F, 7'b1000000}));
        @(negedge clk);
        #2 resetn = 1'b1;
        nd = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (done_d) nd++;
        end
        check("midrst_no_done_d", 64'(nd), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
